eth_pkt_tagger: RTL

ETH_PKT_TAGGER -- requirements
Module: eth_pkt_tagger

---
 rtl/eth_pkg.sv | 21 ++
 rtl/eth_tag_fifo.sv | 37 +++
 rtl/eth_pkt_tagger.sv | 138 +++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared widths, FSM states and tag/beat layouts for the ethernet packet tagger
package eth_pkg;
    localparam int ETH_DATA_W  = 64;
    localparam int ETH_EMPTY_W = 3;
    localparam int ETH_CHAN_W  = 8;
    localparam int TAG_W       = 10;
    localparam int TAG_CHAN_W  = 2;
    localparam int TAG_CNT_W   = 8;
    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
    typedef struct packed {
        logic [TAG_CHAN_W-1:0] chan;
        logic [TAG_CNT_W-1:0]  beats;
    } tag_t;
    typedef struct packed {
        logic [ETH_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [ETH_EMPTY_W-1:0] empty;
        logic [ETH_CHAN_W-1:0]  channel;
    } beat_t;
endpackage

// File: rtl/eth_tag_fifo.sv
// eth_tag_fifo: first-word-fall-through descriptor queue with occupancy count
module eth_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign valid = count != '0;
    assign head = mem[rd_ptr];
    assign do_pop = pop && valid;
    // a full queue takes a new entry only in the cycle its head leaves
    assign do_push = push && (count != FULL || do_pop);
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk_clk)
        if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/eth_pkt_tagger.sv
// eth_pkt_tagger: forwards Avalon-ST packets, truncates overlong ones and queues a per-packet tag
module eth_pkt_tagger
    import eth_pkg::*;
#(
    parameter int MAX_BEATS = 190,
    parameter int TAG_DEPTH = 8
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [ETH_DATA_W-1:0]  snk_data,
    input  logic                   snk_valid,
    output logic                   snk_ready,
    input  logic                   snk_startofpacket,
    input  logic                   snk_endofpacket,
    input  logic [ETH_EMPTY_W-1:0] snk_empty,
    input  logic [ETH_CHAN_W-1:0]  snk_channel,
    output logic [ETH_DATA_W-1:0]  src_data,
    output logic                   src_valid,
    input  logic                   src_ready,
    output logic                   src_startofpacket,
    output logic                   src_endofpacket,
    output logic [ETH_EMPTY_W-1:0] src_empty,
    output logic [ETH_CHAN_W-1:0]  src_channel,
    output logic [TAG_W-1:0]       tag_data,
    output logic                   tag_valid,
    input  logic                   tag_ready,
    output logic [31:0]            pkt_count,
    output logic [15:0]            trunc_count,
    output logic [15:0]            err_count
);
    localparam int CW = $clog2(TAG_DEPTH);
    localparam logic [CW:0] FIFO_FULL = (CW+1)'(TAG_DEPTH);
    localparam logic [TAG_CNT_W-1:0] LAST_BEAT = TAG_CNT_W'(MAX_BEATS);
    state_t state, state_n;
    logic [TAG_CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [TAG_CHAN_W-1:0] chan, chan_n;
    beat_t in_beat, out_beat, sk_beat;
    tag_t tag_in;
    logic acc, fwd, push, inc_pkt, inc_trunc, inc_err;
    logic out_free, sk_valid, sk_valid_n, rdy_n;
    logic [CW:0] tag_count, tag_count_n;
    assign acc = snk_valid && snk_ready;
    assign cnt_inc = cnt + 1'b1;
    assign out_free = src_ready || !src_valid;
    assign sk_valid_n = !out_free && (sk_valid || fwd);
    assign tag_count_n = tag_count + (CW+1)'(push) - (CW+1)'(tag_valid && tag_ready);
    // ready is a flop, so it looks one cycle ahead at skid and tag-queue occupancy
    assign rdy_n = state_n == DROP || (!sk_valid_n && tag_count_n != FIFO_FULL);
    assign {src_data, src_startofpacket, src_endofpacket, src_empty, src_channel} = out_beat;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        chan_n = chan;
        fwd = 1'b0;
        push = 1'b0;
        inc_pkt = 1'b0;
        inc_trunc = 1'b0;
        inc_err = 1'b0;
        in_beat = '{data: snk_data, sop: 1'b0, eop: snk_endofpacket, empty: snk_empty, channel: snk_channel};
        tag_in = '{chan: chan, beats: cnt_inc};
        if (acc)
            case (state)
                IDLE: begin
                    inc_err = !snk_startofpacket;
                    if (snk_startofpacket) begin
                        fwd = 1'b1;
                        in_beat.sop = 1'b1;
                        cnt_n = TAG_CNT_W'(1);
                        chan_n = snk_channel[TAG_CHAN_W-1:0];
                        tag_in = '{chan: snk_channel[TAG_CHAN_W-1:0], beats: TAG_CNT_W'(1)};
                        push = snk_endofpacket;
                        inc_pkt = snk_endofpacket;
                        state_n = snk_endofpacket ? IDLE : PKT;
                    end
                end
                PKT: begin
                    fwd = 1'b1;
                    cnt_n = cnt_inc;
                    inc_err = snk_startofpacket;
                    if (snk_endofpacket) begin
                        push = 1'b1;
                        inc_pkt = 1'b1;
                        state_n = IDLE;
                    end else if (cnt_inc == LAST_BEAT) begin
                        in_beat.eop = 1'b1;
                        in_beat.empty = '0;
                        push = 1'b1;
                        inc_trunc = 1'b1;
                        state_n = DROP;
                    end
                end
                DROP: state_n = snk_endofpacket ? IDLE : DROP;
                default: state_n = IDLE;
            endcase
    end
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) begin
            state <= IDLE;
            cnt <= '0;
            chan <= '0;
            snk_ready <= 1'b0;
            src_valid <= 1'b0;
            out_beat <= '0;
            sk_valid <= 1'b0;
            sk_beat <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            chan <= chan_n;
            snk_ready <= rdy_n;
            sk_valid <= sk_valid_n;
            if (out_free) begin
                src_valid <= sk_valid || fwd;
                if (sk_valid || fwd) out_beat <= sk_valid ? sk_beat : in_beat;
            end else if (fwd)
                sk_beat <= in_beat;
        end
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) begin
            pkt_count <= '0;
            trunc_count <= '0;
            err_count <= '0;
        end else begin
            if (inc_pkt && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
            if (inc_trunc && trunc_count != '1) trunc_count <= trunc_count + 1'b1;
            if (inc_err && err_count != '1) err_count <= err_count + 1'b1;
        end
    eth_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TAG_W)) u_tag_fifo (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .push       (push),
        .push_data  (tag_in),
        .pop        (tag_ready),
        .head       (tag_data),
        .valid      (tag_valid),
        .count      (tag_count)
    );
endmodule
